// File: rtl/float_divider_seq.sv
// rtl/float_divider_seq.sv - iterative radix-2 restoring IEEE-754 floating-point divider
//
// Purpose:
//   Divides a by b one quotient bit per clock. A multi-cycle FSM sequences the
//   work: IDLE -> CLASS -> DIV -> ROUND -> DONE. Special operands short-cut from
//   CLASS straight to DONE. Exponent and mantissa widths are generic, and the
//   default is binary32.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operands a/b valid
//   in_ready   divider can accept operands (IDLE and not in reset)
//   a, b       dividend / divisor, W = 1+EXP_W+MAN_W bits
//   out_valid  result and flags valid (DONE state)
//   out_ready  consumer accepts result
//   result     quotient a/b
//   error      invalid operation, result is canonical qNaN
//   overflow   divide-by-zero or exponent overflow, result is signed Inf
//   underflow  tiny result (denormal or rounded to zero)
//
// Optional macro:
//   FDIV_FTZ_EN  flush denormal inputs and tiny results to signed zero with
//                underflow=1. This build drops the input normaliser and the
//                output denormaliser.
module float_divider_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 error,
  output logic                 overflow,
  output logic                 underflow
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int EW2   = EXP_W + 2;
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int EONES = (1 << EXP_W) - 1;
  localparam int QW    = MAN_W + 3;
  localparam int RW    = MAN_W + 2;
  localparam int MSW   = MAN_W + 2;
  localparam int CNT_W = $clog2(QW + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLASS, S_DIV, S_ROUND, S_DONE} state_t;
  state_t r_state, w_next;

  logic [W-1:0]     r_a, r_b;
  logic             r_sign;
  logic [EW2-1:0]   r_exp;
  logic [RW-1:0]    r_rem;
  logic [MAN_W:0]   r_mb;
  logic [QW-1:0]    r_quo;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_result;
  logic             r_error, r_overflow, r_underflow;

  // ---------------------------------------------------------------- decode
  logic             w_sa, w_sb, w_sign;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_ma, w_mb;
  logic             w_a_ez, w_b_ez, w_a_e1, w_b_e1, w_a_mz, w_b_mz;
  logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

  assign {w_sa, w_ea, w_ma} = r_a;
  assign {w_sb, w_eb, w_mb} = r_b;
  assign w_sign  = w_sa ^ w_sb;
  assign w_a_ez  = (w_ea == '0);
  assign w_b_ez  = (w_eb == '0);
  assign w_a_e1  = (w_ea == {EXP_W{1'b1}});
  assign w_b_e1  = (w_eb == {EXP_W{1'b1}});
  assign w_a_mz  = (w_ma == '0);
  assign w_b_mz  = (w_mb == '0);
  assign w_a_nan = w_a_e1 & ~w_a_mz;
  assign w_b_nan = w_b_e1 & ~w_b_mz;
  assign w_a_inf = w_a_e1 & w_a_mz;
  assign w_b_inf = w_b_e1 & w_b_mz;

`ifdef FDIV_FTZ_EN
  logic w_a_den, w_b_den;
  assign w_a_zero = w_a_ez;
  assign w_b_zero = w_b_ez;
  assign w_a_den  = w_a_ez & ~w_a_mz;
  assign w_b_den  = w_b_ez & ~w_b_mz;
`else
  assign w_a_zero = w_a_ez & w_a_mz;
  assign w_b_zero = w_b_ez & w_b_mz;
`endif

  // ---------------------------------------------------------- special cases
  logic         w_special, w_sp_err, w_sp_ovf, w_sp_unf;
  logic [W-1:0] w_sp_result;

  always_comb begin
    w_special   = 1'b1;
    w_sp_err    = 1'b0;
    w_sp_ovf    = 1'b0;
    w_sp_unf    = 1'b0;
    w_sp_result = '0;
    if (w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf)) begin
      w_sp_result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      w_sp_err    = 1'b1;
    end else if (w_a_inf) begin
      w_sp_result = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_b_zero) begin
      w_sp_result = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_sp_ovf    = 1'b1;
    end else if (w_a_zero | w_b_inf) begin
      w_sp_result = {w_sign, {(W-1){1'b0}}};
    end else begin
      w_special   = 1'b0;
    end
`ifdef FDIV_FTZ_EN
    // A flushed denormal input is reported unless a stronger flag already applies.
    if (w_special & ~w_sp_err & ~w_sp_ovf & (w_a_den | w_b_den))
      w_sp_unf = 1'b1;
`endif
  end

  // ------------------------------------------- operand normalise + exponent
  // Exponents are EXP_W+2 bit two's complement from here on.
  logic [MAN_W:0] w_a_man, w_b_man;
  logic [EW2-1:0] w_a_exp, w_b_exp, w_e_diff;

`ifdef FDIV_FTZ_EN
  assign w_a_man = {1'b1, w_ma};
  assign w_b_man = {1'b1, w_mb};
  assign w_a_exp = {2'b00, w_ea};
  assign w_b_exp = {2'b00, w_eb};
`else
  localparam int LZ_W = $clog2(MAN_W + 1);

  function automatic logic [LZ_W-1:0] lzc(input logic [MAN_W-1:0] v);
    lzc = LZ_W'(MAN_W);
    for (int i = 0; i < MAN_W; i++)
      if (v[i]) lzc = LZ_W'(MAN_W - 1 - i);
  endfunction

  logic [LZ_W-1:0] w_a_lz, w_b_lz;
  assign w_a_lz = lzc(w_ma);
  assign w_b_lz = lzc(w_mb);

  // A denormal shifts its leading one into the hidden-bit slot. Its effective
  // exponent is then 1-(lz+1) = -lz.
  assign w_a_man = w_a_ez ? ({1'b0, w_ma} << (w_a_lz + LZ_W'(1))) : {1'b1, w_ma};
  assign w_b_man = w_b_ez ? ({1'b0, w_mb} << (w_b_lz + LZ_W'(1))) : {1'b1, w_mb};
  assign w_a_exp = w_a_ez ? (EW2'(0) - EW2'(w_a_lz)) : {2'b00, w_ea};
  assign w_b_exp = w_b_ez ? (EW2'(0) - EW2'(w_b_lz)) : {2'b00, w_eb};
`endif

  assign w_e_diff = w_a_exp - w_b_exp + EW2'(BIAS);

  // ----------------------------------------------------- restoring divider
  // The remainder stays below 2*divisor, so RW bits hold it. The subtracted
  // value is below the divisor, so the left shift loses nothing.
  logic          w_ge;
  logic [RW-1:0] w_sub;
  assign w_ge  = (r_rem >= {1'b0, r_mb});
  assign w_sub = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;

  // ---------------------------------------------------- normalise + round
  logic [MAN_W:0]   w_m, w_rm;
  logic             w_g, w_s, w_rg, w_rs, w_inc, w_tiny;
  logic [EW2-1:0]   w_e, w_ef;
  logic [MSW-1:0]   w_msum;
  logic [W-1:0]     w_rnd_result;
  logic             w_rnd_ovf, w_rnd_unf;
`ifndef FDIV_FTZ_EN
  logic [EW2-1:0]   w_sh;
  logic [RW-1:0]    w_ext, w_shd, w_mask;
`endif

  always_comb begin
    // The quotient lies in [0.5, 2). A clear MSB needs one left shift.
    if (r_quo[QW-1]) begin
      w_m = r_quo[QW-1:2];
      w_g = r_quo[1];
      w_s = r_quo[0] | (|r_rem);
      w_e = r_exp;
    end else begin
      w_m = r_quo[QW-2:1];
      w_g = r_quo[0];
      w_s = |r_rem;
      w_e = r_exp - EW2'(1);
    end
    w_tiny = w_e[EW2-1] | (w_e == '0);
    w_rm   = w_m;
    w_rg   = w_g;
    w_rs   = w_s;
`ifndef FDIV_FTZ_EN
    // Denormalise: shift right by 1-e. Every bit shifted out goes into sticky.
    w_sh = EW2'(1) - w_e;
    if (w_sh > EW2'(RW)) w_sh = EW2'(RW);
    w_ext  = {w_m, w_g};
    w_shd  = w_ext >> w_sh;
    w_mask = ({{(RW-1){1'b0}}, 1'b1} << w_sh) - RW'(1);
    if (w_tiny) begin
      w_rm = w_shd[RW-1:1];
      w_rg = w_shd[0];
      w_rs = w_s | (|(w_ext & w_mask));
    end
`endif
    w_inc        = w_rg & (w_rs | w_rm[0]);
    w_msum       = {1'b0, w_rm} + MSW'(w_inc);
    w_ef         = w_e;
    w_rnd_ovf    = 1'b0;
    w_rnd_unf    = 1'b0;
    w_rnd_result = '0;
    if (w_tiny) begin
`ifdef FDIV_FTZ_EN
      w_rnd_result = {r_sign, {(W-1){1'b0}}};
`else
      // A carry into the hidden bit lands exactly on min normal (exponent 1).
      w_rnd_result = {r_sign, {(EXP_W-1){1'b0}}, w_msum[MAN_W], w_msum[MAN_W-1:0]};
`endif
      w_rnd_unf = 1'b1;
    end else begin
      if (w_msum[MAN_W+1]) w_ef = w_e + EW2'(1);
      if (w_ef >= EW2'(EONES)) begin
        w_rnd_result = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        w_rnd_ovf    = 1'b1;
      end else begin
        w_rnd_result = {r_sign, w_ef[EXP_W-1:0],
                        w_msum[MAN_W+1] ? w_msum[MAN_W:1] : w_msum[MAN_W-1:0]};
      end
    end
  end

  // ----------------------------------------------------------------- FSM
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_CLASS;
      S_CLASS: w_next = w_special ? S_DONE : S_DIV;
      S_DIV:   if (r_cnt == CNT_W'(QW - 1)) w_next = S_ROUND;
      S_ROUND: w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_result    <= '0;
      r_error     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a <= a;
            r_b <= b;
          end
        end
        S_CLASS: begin
          r_sign <= w_sign;
          r_exp  <= w_e_diff;
          r_rem  <= {1'b0, w_a_man};
          r_mb   <= w_b_man;
          r_quo  <= '0;
          r_cnt  <= '0;
          if (w_special) begin
            r_result    <= w_sp_result;
            r_error     <= w_sp_err;
            r_overflow  <= w_sp_ovf;
            r_underflow <= w_sp_unf;
          end
        end
        S_DIV: begin
          r_rem <= w_sub << 1;
          r_quo <= {r_quo[QW-2:0], w_ge};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_ROUND: begin
          r_result    <= w_rnd_result;
          r_error     <= 1'b0;
          r_overflow  <= w_rnd_ovf;
          r_underflow <= w_rnd_unf;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign error     = r_error;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_float_divider_seq.sv
// tb/tb_float_divider_seq.sv - directed bench for float_divider_seq (binary32)
module tb_float_divider_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        error, overflow, underflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  float_divider_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .error     (error),
    .overflow  (overflow),
    .underflow (underflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // The accepting edge counts as edge 1. ef = {error, overflow, underflow}.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                        input logic [31:0] er, input logic [2:0] ef,
                        input int elat, input int hold);
    int          lat;
    int          guard;
    logic [31:0] snap;
    logic [2:0]  fsnap;
    logic        stable;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_eq({tag, " in_ready"}, 32'(in_ready), 32'd1);
    a = ta;
    b = tbv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, " latency"}, 32'(lat), 32'(elat));
    check_eq({tag, " result"}, result, er);
    check_eq({tag, " flags"}, {29'd0, error, overflow, underflow}, {29'd0, ef});
    snap   = result;
    fsnap  = {error, overflow, underflow};
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || result !== snap || {error, overflow, underflow} !== fsnap)
        stable = 1'b0;
    end
    if (hold > 0) check_eq({tag, " hold"}, 32'(stable), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, " drain"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset result", result, 32'h0);
    check_eq("reset ctl", {27'd0, in_ready, out_valid, error, overflow, underflow}, 32'd0);
    rst = 1'b0;

    run_op("div4_2",   32'h40800000, 32'h40000000, 32'h40000000, 3'b000, 29, 0);
    run_op("div1_3",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000, 29, 0);
    run_op("div_by0",  32'h40A00000, 32'h00000000, 32'h7F800000, 3'b010, 2, 0);
    run_op("zero_0",   32'h00000000, 32'h00000000, 32'h7FC00000, 3'b100, 2, 0);
    run_op("inf_inf",  32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b100, 2, 0);
    run_op("nan_in",   32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b100, 2, 0);
    run_op("inf_fin",  32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 2, 0);
    run_op("fin_inf",  32'h3F800000, 32'hFF800000, 32'h80000000, 3'b000, 2, 0);
    run_op("ovf",      32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 3'b010, 29, 0);
    run_op("neg",      32'hC0C00000, 32'h40400000, 32'hC0000000, 3'b000, 29, 0);
`ifdef FDIV_FTZ_EN
    run_op("tiny",     32'h00400000, 32'h40000000, 32'h00000000, 3'b001, 2, 0);
    run_op("tie_zero", 32'h00000001, 32'h40000000, 32'h00000000, 3'b001, 2, 0);
    run_op("tie_up",   32'h00000003, 32'h40000000, 32'h00000000, 3'b001, 2, 0);
`else
    run_op("tiny",     32'h00400000, 32'h40000000, 32'h00200000, 3'b001, 29, 0);
    run_op("tie_zero", 32'h00000001, 32'h40000000, 32'h00000000, 3'b001, 29, 0);
    run_op("tie_up",   32'h00000003, 32'h40000000, 32'h00000002, 3'b001, 29, 0);
`endif
    run_op("bp",       32'h40800000, 32'h40000000, 32'h40000000, 3'b000, 29, 5);
    run_op("after_bp", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000, 29, 0);

    // Abort a division with a one-cycle reset on edge 10.
    @(negedge clk);
    a        = 32'h40800000;
    b        = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("abort in_ready low", 32'(in_ready), 32'd0);
    rst = 1'b0;
    check_eq("abort result", result, 32'h0);
    check_eq("abort flags", {29'd0, error, overflow, underflow}, 32'd0);
    @(negedge clk);
    check_eq("abort in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check_eq("abort no out_valid", 32'(seen), 32'd0);
    run_op("post_rst", 32'h40800000, 32'h40000000, 32'h40000000, 3'b000, 29, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
